cache_ctrl_dm: RTL and testbench
================================

Name: cache_ctrl_dm

Overview:
Direct-mapped, write-through, no-write-allocate cache controller that sits directly upstream of the 64-bit byte-enabled single-port data SRAM.
- Owns the tag/valid store in flops.
- Drives the SRAM's CSel/WrEn/BEn/Addr/WrData and consumes its RdData.
- Refills and writes through to a next-level memory over a req/gnt/rvalid interface.
- Core side is a single-outstanding req/gnt/rvalid port with 64-bit words.

Parameters:
- ADDR_WIDTH, 9, index bits; must equal the data SRAM ADDR_WIDTH; sets = 2**ADDR_WIDTH.
- AW, 32, core/memory byte-address width.
- ARR_LATENCY, 1, SRAM read latency in cycles: 1 when SRAM OUT_REGS=0, 2 when OUT_REGS=1.

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  asynchronous active-low reset
- Req_SI  in  1  core request
- We_SI  in  1  core write (1) / read (0)
- BEn_SI  in  8  core byte enables (writes)
- Addr_DI  in  AW  core byte address; bits [2:0] ignored
- WData_DI  in  64  core write data
- Gnt_SO  out  1  request accepted
- RValid_SO  out  1  response valid (read data or write ack)
- RData_DO  out  64  read data; 0 on write ack
- MemReq_SO  out  1  memory request
- MemWe_SO  out  1  memory write
- MemBEn_SO  out  8  memory byte enables
- MemAddr_DO  out  AW  memory address, [2:0]=0
- MemWData_DO  out  64  memory write data
- MemGnt_SI  in  1  memory accepted
- MemRValid_SI  in  1  memory response (read data or write ack)
- MemRData_DI  in  64  memory read data
- ArrCSel_SO  out  1  SRAM chip select
- ArrWrEn_SO  out  1  SRAM write enable
- ArrBEn_SO  out  8  SRAM byte enables
- ArrAddr_DO  out  ADDR_WIDTH  SRAM index
- ArrWrData_DO  out  64  SRAM write data
- ArrRdData_DI  in  64  SRAM read data
- HitCnt_DO  out  32  hit counter (optional feature)
- MissCnt_DO  out  32  miss counter (optional feature)

Behaviour:
- Address split: index = Addr[ADDR_WIDTH+2:3]; tag = Addr[AW-1:ADDR_WIDTH+3].
- Tag store: one valid bit plus tag per set.
- Reset (async): all valid=0, FSM=IDLE, all outputs 0, latched request cleared.
- Gnt_SO=1 only in IDLE while Req_SI=1 (combinational). At that edge, addr/we/ben/wdata are latched. Hit = valid[index] && tag match, evaluated in IDLE from the live inputs.
- IDLE, read accepted: ArrCSel=1, ArrWrEn=0, ArrAddr=index. Hit -> RD_HIT; miss -> MISS_REQ (no SRAM access on a read miss).
- RD_HIT: wait ARR_LATENCY cycles counted from the CSel edge. Then RValid=1 for one cycle with RData=ArrRdData_DI. Then IDLE. HitCnt increments.
- MISS_REQ: MemReq=1, MemWe=0, MemBEn=8'hFF, MemAddr={latched addr[AW-1:3],3'b0}. Hold all until MemGnt_SI, then MISS_WAIT. MissCnt increments on entry to MISS_REQ.
- MISS_WAIT: on MemRValid_SI, in the same cycle:
  - SRAM write: ArrCSel=1, ArrWrEn=1, ArrBEn=8'hFF, ArrWrData=MemRData_DI.
  - Tag update: valid[index]=1, tag[index]=latched tag.
  - Core response: RValid=1, RData=MemRData_DI.
  - Next state: IDLE. Refill-to-response latency is 0 cycles after MemRValid.
- IDLE, write accepted:
  - Hit: SRAM written the same cycle, ArrCSel=1, ArrWrEn=1, ArrBEn=BEn_SI, ArrWrData=WData_DI. HitCnt increments.
  - Miss: no SRAM access, no tag change. MissCnt increments.
  - Both cases go to WR_MEM.
- WR_MEM: MemReq=1, MemWe=1, MemBEn/MemWData from latched values. Hold until MemGnt_SI, then WR_WAIT.
- WR_WAIT: on MemRValid_SI, RValid=1 with RData=0, then IDLE.
- Responses are strictly in order; at most one transaction outstanding. Back-to-back requests: next Gnt no earlier than the cycle after RValid.
- Conflict miss replaces the set unconditionally; no dirty state exists.
- MemRValid_SI is ignored outside MISS_WAIT/WR_WAIT, including a stale response arriving after a mid-transaction reset.
- BEn_SI=0 write: forwarded as-is; hit SRAM write changes no bytes.
- Counters: 32-bit, saturate at 32'hFFFF_FFFF, reset to 0.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: HitCnt_DO and MissCnt_DO implemented exactly as described in Behaviour.
- Undefined: no counter flops are generated; HitCnt_DO and MissCnt_DO are tied to 0. Port list is unchanged.

Test Plan:
1. After reset, read 0x0000_1008 -> miss. MemReq with MemAddr=0x0000_1008. Return 64'h1122334455667788 -> RValid with that data. SRAM written at index 1 with BEn=FF. MissCnt=1.
2. Repeat the read of 0x0000_1008 -> no MemReq. RValid exactly ARR_LATENCY cycles after Gnt with 64'h1122334455667788 (run with ARR_LATENCY=1 and 2). HitCnt=1.
3. Write 0x0000_1008, BEn=8'h0F, data 64'hAAAAAAAA_BBBBBBBB -> SRAM write with BEn=0F the same cycle as Gnt. MemReq with MemWe=1. Ack gives RValid with RData=0. Subsequent read returns 64'h11223344_BBBBBBBB.
4. Write-miss to 0x0000_2008 -> SRAM untouched; read 0x0000_1008 still hits. Then read 0x0000_2008 -> miss refill evicts set 1; read 0x0000_1008 misses again.
5. Assert Rst_RBI low during MISS_WAIT, then send MemRValid after release -> ignored, RValid stays 0. Next read of 0x0000_1008 misses (valid cleared).
6. Hold Req_SI during a refill -> Gnt=0 until the cycle after RValid. With CACHE_STATS_EN undefined, counters read 0 throughout.

Source files
------------

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-write-allocate cache controller in front of a byte-enabled data SRAM.
// Optional hit/miss statistics counters are built only when CACHE_STATS_EN is defined.
module cache_ctrl_dm #(
  parameter int ADDR_WIDTH  = 9,
  parameter int AW          = 32,
  parameter int ARR_LATENCY = 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Req_SI,
  input  logic                  We_SI,
  input  logic [7:0]            BEn_SI,
  input  logic [AW-1:0]         Addr_DI,
  input  logic [63:0]           WData_DI,
  output logic                  Gnt_SO,
  output logic                  RValid_SO,
  output logic [63:0]           RData_DO,
  output logic                  MemReq_SO,
  output logic                  MemWe_SO,
  output logic [7:0]            MemBEn_SO,
  output logic [AW-1:0]         MemAddr_DO,
  output logic [63:0]           MemWData_DO,
  input  logic                  MemGnt_SI,
  input  logic                  MemRValid_SI,
  input  logic [63:0]           MemRData_DI,
  output logic                  ArrCSel_SO,
  output logic                  ArrWrEn_SO,
  output logic [7:0]            ArrBEn_SO,
  output logic [ADDR_WIDTH-1:0] ArrAddr_DO,
  output logic [63:0]           ArrWrData_DO,
  input  logic [63:0]           ArrRdData_DI,
  output logic [31:0]           HitCnt_DO,
  output logic [31:0]           MissCnt_DO
);

  localparam int SETS  = 2 ** ADDR_WIDTH;
  localparam int TAG_W = AW - ADDR_WIDTH - 3;
  localparam logic [3:0] LAT_C = 4'(ARR_LATENCY);

  typedef enum logic [2:0] {IDLE, RD_HIT, MISS_REQ, MISS_WAIT, WR_MEM, WR_WAIT} state_e;

  state_e            state_q;
  logic [AW-4:0]     waddr_q;
  logic [7:0]        ben_q;
  logic [63:0]       wdata_q;
  logic [3:0]        lat_q;
  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q [SETS];

  logic [ADDR_WIDTH-1:0] in_idx, q_idx;
  logic [TAG_W-1:0]      in_tag, q_tag;
  logic                  accept, hit, lat_done, refill;
  logic                  unused_addr_lsb;

  assign in_idx          = Addr_DI[ADDR_WIDTH+2:3];
  assign in_tag          = Addr_DI[AW-1:ADDR_WIDTH+3];
  assign q_idx           = waddr_q[ADDR_WIDTH-1:0];
  assign q_tag           = waddr_q[AW-4:ADDR_WIDTH];
  assign accept          = (state_q == IDLE) && Req_SI;
  assign hit             = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign lat_done        = (lat_q == LAT_C);
  assign refill          = (state_q == MISS_WAIT) && MemRValid_SI;
  assign unused_addr_lsb = ^Addr_DI[2:0];

  // Core responses and SRAM writes are combinational so hits write in the grant cycle and refills answer with zero added latency
  always_comb begin
    Gnt_SO       = accept;
    RValid_SO    = 1'b0;
    RData_DO     = '0;
    MemReq_SO    = 1'b0;
    MemWe_SO     = 1'b0;
    MemBEn_SO    = '0;
    MemAddr_DO   = '0;
    MemWData_DO  = '0;
    ArrCSel_SO   = 1'b0;
    ArrWrEn_SO   = 1'b0;
    ArrBEn_SO    = '0;
    ArrAddr_DO   = '0;
    ArrWrData_DO = '0;
    unique case (state_q)
      IDLE: begin
        if (accept && hit) begin
          ArrCSel_SO = 1'b1;
          ArrWrEn_SO = We_SI;
          ArrAddr_DO = in_idx;
          if (We_SI) begin
            ArrBEn_SO    = BEn_SI;
            ArrWrData_DO = WData_DI;
          end
        end
      end
      RD_HIT: begin
        if (lat_done) begin
          RValid_SO = 1'b1;
          RData_DO  = ArrRdData_DI;
        end
      end
      MISS_REQ: begin
        MemReq_SO  = 1'b1;
        MemBEn_SO  = 8'hFF;
        MemAddr_DO = {waddr_q, 3'b000};
      end
      MISS_WAIT: begin
        if (MemRValid_SI) begin
          ArrCSel_SO   = 1'b1;
          ArrWrEn_SO   = 1'b1;
          ArrBEn_SO    = 8'hFF;
          ArrAddr_DO   = q_idx;
          ArrWrData_DO = MemRData_DI;
          RValid_SO    = 1'b1;
          RData_DO     = MemRData_DI;
        end
      end
      WR_MEM: begin
        MemReq_SO   = 1'b1;
        MemWe_SO    = 1'b1;
        MemBEn_SO   = ben_q;
        MemAddr_DO  = {waddr_q, 3'b000};
        MemWData_DO = wdata_q;
      end
      WR_WAIT: RValid_SO = MemRValid_SI;
      default: ;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= IDLE;
      waddr_q <= '0;
      ben_q   <= '0;
      wdata_q <= '0;
      lat_q   <= '0;
      valid_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            waddr_q <= Addr_DI[AW-1:3];
            ben_q   <= BEn_SI;
            wdata_q <= WData_DI;
            lat_q   <= 4'd1;
            if (We_SI)    state_q <= WR_MEM;
            else if (hit) state_q <= RD_HIT;
            else          state_q <= MISS_REQ;
          end
        end
        RD_HIT: begin
          if (lat_done) state_q <= IDLE;
          else          lat_q   <= lat_q + 4'd1;
        end
        MISS_REQ:  if (MemGnt_SI) state_q <= MISS_WAIT;
        MISS_WAIT: begin
          if (MemRValid_SI) begin
            valid_q[q_idx] <= 1'b1;
            state_q        <= IDLE;
          end
        end
        WR_MEM:    if (MemGnt_SI) state_q <= WR_WAIT;
        WR_WAIT:   if (MemRValid_SI) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  // Tags are only meaningful behind a set valid bit, so they need no reset
  always_ff @(posedge Clk_CI) begin
    if (refill) tag_q[q_idx] <= q_tag;
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit_inc, miss_inc;

  assign hit_inc  = (accept && We_SI && hit) || ((state_q == RD_HIT) && lat_done);
  assign miss_inc = accept && !hit;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign HitCnt_DO  = hit_cnt_q;
  assign MissCnt_DO = miss_cnt_q;
`else
  assign HitCnt_DO  = '0;
  assign MissCnt_DO = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Bench for cache_ctrl_dm: SRAM and next-level memory models plus a set/tag reference model of the cache.
module tb_cache_ctrl_dm #(parameter int ARR_LATENCY = 1);

  logic        Clk_CI = 1'b0;
  logic        Rst_RBI = 1'b0;
  logic        Req_SI = 1'b0, We_SI = 1'b0;
  logic [7:0]  BEn_SI = '0;
  logic [31:0] Addr_DI = '0;
  logic [63:0] WData_DI = '0;
  logic        Gnt_SO, RValid_SO;
  logic [63:0] RData_DO;
  logic        MemReq_SO, MemWe_SO;
  logic [7:0]  MemBEn_SO;
  logic [31:0] MemAddr_DO;
  logic [63:0] MemWData_DO;
  logic        MemGnt_SI = 1'b0, MemRValid_SI = 1'b0;
  logic [63:0] MemRData_DI = '0;
  logic        ArrCSel_SO, ArrWrEn_SO;
  logic [7:0]  ArrBEn_SO;
  logic [8:0]  ArrAddr_DO;
  logic [63:0] ArrWrData_DO, ArrRdData_DI;
  logic [31:0] HitCnt_DO, MissCnt_DO;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cache_ctrl_dm #(.ADDR_WIDTH(9), .AW(32), .ARR_LATENCY(ARR_LATENCY)) dut (
    .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Req_SI(Req_SI), .We_SI(We_SI), .BEn_SI(BEn_SI),
    .Addr_DI(Addr_DI), .WData_DI(WData_DI), .Gnt_SO(Gnt_SO), .RValid_SO(RValid_SO), .RData_DO(RData_DO),
    .MemReq_SO(MemReq_SO), .MemWe_SO(MemWe_SO), .MemBEn_SO(MemBEn_SO), .MemAddr_DO(MemAddr_DO),
    .MemWData_DO(MemWData_DO), .MemGnt_SI(MemGnt_SI), .MemRValid_SI(MemRValid_SI), .MemRData_DI(MemRData_DI),
    .ArrCSel_SO(ArrCSel_SO), .ArrWrEn_SO(ArrWrEn_SO), .ArrBEn_SO(ArrBEn_SO), .ArrAddr_DO(ArrAddr_DO),
    .ArrWrData_DO(ArrWrData_DO), .ArrRdData_DI(ArrRdData_DI), .HitCnt_DO(HitCnt_DO), .MissCnt_DO(MissCnt_DO)
  );

  initial forever #5 Clk_CI = ~Clk_CI;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw, input logic [7:0] ben);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (ben[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // SRAM model: byte-enabled writes, reads returned after ARR_LATENCY edges; every access is logged
  logic [63:0] sram [512];
  logic [63:0] rd1 = '0, rd2 = '0;
  int          wr_cnt = 0, rd_cnt = 0, last_wr_cyc = -1;
  logic [8:0]  last_wr_addr = '0;
  logic [7:0]  last_wr_ben = '0;
  logic [63:0] last_wr_data = '0;

  always @(posedge Clk_CI) begin
    cyc <= cyc + 1;
    rd2 <= rd1;
    if (ArrCSel_SO === 1'b1) begin
      if (ArrWrEn_SO === 1'b1) begin
        sram[ArrAddr_DO] <= merge(sram[ArrAddr_DO], ArrWrData_DO, ArrBEn_SO);
        wr_cnt       <= wr_cnt + 1;
        last_wr_cyc  <= cyc;
        last_wr_addr <= ArrAddr_DO;
        last_wr_ben  <= ArrBEn_SO;
        last_wr_data <= ArrWrData_DO;
      end else begin
        rd1    <= sram[ArrAddr_DO];
        rd_cnt <= rd_cnt + 1;
      end
    end
  end
  assign ArrRdData_DI = (ARR_LATENCY == 2) ? rd2 : rd1;

  function automatic logic [63:0] dflt(input logic [28:0] w);
    return {3'b000, w, 3'b101, w ^ 29'h0ACE_1234};
  endfunction

  // Next-level memory: grants and answers after random delays; hold_rvalid parks the response
  logic [63:0] dut_mem [logic [28:0]];
  logic [63:0] ref_mem [logic [28:0]];
  int          req_cnt = 0;
  bit          hold_rvalid = 1'b0;
  logic [31:0] last_req_addr = '0;
  logic        last_req_we = 1'b0;
  logic [7:0]  last_req_ben = '0;
  logic [63:0] last_req_wdata = '0;

  initial begin
    logic [28:0] w;
    logic [63:0] cur;
    forever begin
      @(negedge Clk_CI);
      if (MemReq_SO === 1'b1) begin
        repeat ($urandom_range(0, 2)) @(negedge Clk_CI);
        MemGnt_SI      = 1'b1;
        last_req_addr  = MemAddr_DO;
        last_req_we    = MemWe_SO;
        last_req_ben   = MemBEn_SO;
        last_req_wdata = MemWData_DO;
        req_cnt++;
        w   = MemAddr_DO[31:3];
        cur = dut_mem.exists(w) ? dut_mem[w] : dflt(w);
        if (MemWe_SO === 1'b1) dut_mem[w] = merge(cur, MemWData_DO, MemBEn_SO);
        @(negedge Clk_CI);
        MemGnt_SI = 1'b0;
        while (hold_rvalid) @(negedge Clk_CI);
        repeat ($urandom_range(0, 2)) @(negedge Clk_CI);
        MemRValid_SI = 1'b1;
        MemRData_DI  = last_req_we ? {$urandom, $urandom} : cur;
        @(negedge Clk_CI);
        MemRValid_SI = 1'b0;
        MemRData_DI  = '0;
      end
    end
  end

  // Reference model: per-set valid/tag and a flat memory; a write-through cache always reads back memory content
  bit          valid_m [512];
  logic [19:0] tag_m [512];
  int          hit_m = 0, miss_m = 0;

  task automatic model_step(input bit we, input logic [31:0] a, input logic [7:0] ben, input logic [63:0] wd,
                            output bit hit, output logic [63:0] rd);
    int          s;
    logic [19:0] t;
    logic [28:0] w;
    logic [63:0] cur;
    s   = int'(a[11:3]);
    t   = a[31:12];
    w   = a[31:3];
    cur = ref_mem.exists(w) ? ref_mem[w] : dflt(w);
    hit = valid_m[s] && (tag_m[s] == t);
    if (hit) hit_m++; else miss_m++;
    if (we) begin
      ref_mem[w] = merge(cur, wd, ben);
      rd = '0;
    end else begin
      rd = cur;
      if (!hit) begin
        valid_m[s] = 1'b1;
        tag_m[s]   = t;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 512; i++) valid_m[i] = 1'b0;
    hit_m  = 0;
    miss_m = 0;
  endtask

  function automatic logic [31:0] exp_hits();
`ifdef CACHE_STATS_EN
    return 32'(hit_m);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_misses();
`ifdef CACHE_STATS_EN
    return 32'(miss_m);
`else
    return 32'd0;
`endif
  endfunction

  // Core driver: entered and left on a falling edge; reports grant/response cycles, no checking
  task automatic core_access(input bit we, input logic [31:0] a, input logic [7:0] ben, input logic [63:0] wd,
                             output logic [63:0] rd, output int gc, output int rvc, output bit ok);
    int n;
    ok = 1'b0; rd = 'x; gc = -1; rvc = -1;
    Req_SI = 1'b1; We_SI = we; Addr_DI = a; BEn_SI = ben; WData_DI = wd;
    #1;
    n = 0;
    while (Gnt_SO !== 1'b1 && n < 200) begin @(negedge Clk_CI); #1; n++; end
    if (Gnt_SO !== 1'b1) begin Req_SI = 1'b0; return; end
    gc = cyc;
    @(negedge Clk_CI);
    Req_SI = 1'b0; We_SI = 1'b0; BEn_SI = '0; WData_DI = '0;
    #1;
    n = 0;
    while (RValid_SO !== 1'b1 && n < 200) begin @(negedge Clk_CI); #1; n++; end
    if (RValid_SO !== 1'b1) return;
    rd  = RData_DO;
    rvc = cyc;
    ok  = 1'b1;
    @(negedge Clk_CI);
  endtask

  task automatic test_reset();
    Rst_RBI = 1'b0;
    repeat (2) @(negedge Clk_CI);
    #1;
    checks++; if ({Gnt_SO, RValid_SO, MemReq_SO, ArrCSel_SO} !== 4'b0) begin errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {Gnt_SO, RValid_SO, MemReq_SO, ArrCSel_SO}); end
    checks++; if ({HitCnt_DO, MissCnt_DO} !== 64'd0) begin errors++;
      $display("[TB] FAIL reset_counters: got %h/%h expected 0/0", HitCnt_DO, MissCnt_DO); end
    @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    model_reset();
    @(negedge Clk_CI);
  endtask

  task automatic test_read_miss();
    logic [63:0] rd, exp; bit hit, ok; int gc, rvc, r0, w0;
    dut_mem[29'(32'h1008 >> 3)] = 64'h1122334455667788;
    ref_mem[29'(32'h1008 >> 3)] = 64'h1122334455667788;
    r0 = req_cnt; w0 = wr_cnt;
    model_step(1'b0, 32'h0000_1008, 8'h00, 64'd0, hit, exp);
    core_access(1'b0, 32'h0000_1008, 8'h00, 64'd0, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("[TB] FAIL miss_handshake: got timeout expected response"); end
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL miss_data: got %h expected 1122334455667788", rd); end
    checks++; if (req_cnt - r0 != 1 || last_req_addr !== 32'h0000_1008 || last_req_we !== 1'b0 || last_req_ben !== 8'hFF) begin errors++;
      $display("[TB] FAIL miss_memreq: got n=%0d addr=%h we=%b ben=%h expected 1 00001008 0 ff", req_cnt - r0, last_req_addr, last_req_we, last_req_ben); end
    checks++; if (wr_cnt - w0 != 1 || last_wr_addr !== 9'd1 || last_wr_ben !== 8'hFF || last_wr_data !== 64'h1122334455667788 || last_wr_cyc != rvc) begin errors++;
      $display("[TB] FAIL miss_refill: got n=%0d idx=%0d ben=%h data=%h cyc=%0d expected 1 1 ff 1122334455667788 %0d", wr_cnt - w0, last_wr_addr, last_wr_ben, last_wr_data, last_wr_cyc, rvc); end
    checks++; if (MissCnt_DO !== exp_misses()) begin errors++; $display("[TB] FAIL miss_cnt: got %0d expected %0d", MissCnt_DO, exp_misses()); end
  endtask

  task automatic test_read_hit();
    logic [63:0] rd, exp; bit hit, ok; int gc, rvc, r0, c0;
    r0 = req_cnt; c0 = rd_cnt;
    model_step(1'b0, 32'h0000_1008, 8'h00, 64'd0, hit, exp);
    core_access(1'b0, 32'h0000_1008, 8'h00, 64'd0, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || rd !== 64'h1122334455667788) begin errors++; $display("[TB] FAIL hit_data: got %h expected 1122334455667788", rd); end
    checks++; if (rvc - gc != ARR_LATENCY) begin errors++; $display("[TB] FAIL hit_latency: got %0d expected %0d", rvc - gc, ARR_LATENCY); end
    checks++; if (req_cnt != r0 || rd_cnt - c0 != 1) begin errors++; $display("[TB] FAIL hit_no_mem: got memreqs=%0d sramreads=%0d expected 0 1", req_cnt - r0, rd_cnt - c0); end
    checks++; if (HitCnt_DO !== exp_hits()) begin errors++; $display("[TB] FAIL hit_cnt: got %0d expected %0d", HitCnt_DO, exp_hits()); end
  endtask

  task automatic test_write_hit();
    logic [63:0] rd, exp; bit hit, ok; int gc, rvc, r0, w0;
    r0 = req_cnt; w0 = wr_cnt;
    model_step(1'b1, 32'h0000_1008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, hit, exp);
    core_access(1'b1, 32'h0000_1008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || rd !== 64'd0) begin errors++; $display("[TB] FAIL wr_ack: got ok=%b data=%h expected 1 0", ok, rd); end
    checks++; if (wr_cnt - w0 != 1 || last_wr_cyc != gc || last_wr_ben !== 8'h0F || last_wr_addr !== 9'd1 || last_wr_data !== 64'hAAAAAAAA_BBBBBBBB) begin errors++;
      $display("[TB] FAIL wr_hit_sram: got n=%0d cyc=%0d ben=%h idx=%0d data=%h expected 1 %0d 0f 1 aaaaaaaabbbbbbbb", wr_cnt - w0, last_wr_cyc, last_wr_ben, last_wr_addr, last_wr_data, gc); end
    checks++; if (req_cnt - r0 != 1 || last_req_we !== 1'b1 || last_req_ben !== 8'h0F || last_req_wdata !== 64'hAAAAAAAA_BBBBBBBB || last_req_addr !== 32'h1008) begin errors++;
      $display("[TB] FAIL wr_memreq: got n=%0d we=%b ben=%h data=%h addr=%h expected 1 1 0f aaaaaaaabbbbbbbb 00001008", req_cnt - r0, last_req_we, last_req_ben, last_req_wdata, last_req_addr); end
    r0 = req_cnt;
    model_step(1'b0, 32'h0000_1008, 8'h00, 64'd0, hit, exp);
    core_access(1'b0, 32'h0000_1008, 8'h00, 64'd0, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || rd !== 64'h11223344_BBBBBBBB || req_cnt != r0) begin errors++;
      $display("[TB] FAIL wr_readback: got %h memreqs=%0d expected 11223344bbbbbbbb 0", rd, req_cnt - r0); end
  endtask

  task automatic test_write_miss_evict();
    logic [63:0] rd, exp; bit hit, ok; int gc, rvc, r0, w0;
    r0 = req_cnt; w0 = wr_cnt;
    model_step(1'b1, 32'h0000_2008, 8'hFF, 64'hDEADBEEF_CAFEF00D, hit, exp);
    core_access(1'b1, 32'h0000_2008, 8'hFF, 64'hDEADBEEF_CAFEF00D, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || wr_cnt != w0 || req_cnt - r0 != 1) begin errors++;
      $display("[TB] FAIL wmiss_sram_untouched: got sramwrites=%0d memreqs=%0d expected 0 1", wr_cnt - w0, req_cnt - r0); end
    r0 = req_cnt;
    model_step(1'b0, 32'h0000_1008, 8'h00, 64'd0, hit, exp);
    core_access(1'b0, 32'h0000_1008, 8'h00, 64'd0, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || req_cnt != r0 || rd !== 64'h11223344_BBBBBBBB) begin errors++;
      $display("[TB] FAIL wmiss_still_hit: got %h memreqs=%0d expected 11223344bbbbbbbb 0", rd, req_cnt - r0); end
    r0 = req_cnt;
    model_step(1'b0, 32'h0000_2008, 8'h00, 64'd0, hit, exp);
    core_access(1'b0, 32'h0000_2008, 8'h00, 64'd0, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || req_cnt - r0 != 1 || rd !== 64'hDEADBEEF_CAFEF00D) begin errors++;
      $display("[TB] FAIL conflict_refill: got %h memreqs=%0d expected deadbeefcafef00d 1", rd, req_cnt - r0); end
    r0 = req_cnt;
    model_step(1'b0, 32'h0000_1008, 8'h00, 64'd0, hit, exp);
    core_access(1'b0, 32'h0000_1008, 8'h00, 64'd0, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || req_cnt - r0 != 1 || rd !== 64'h11223344_BBBBBBBB) begin errors++;
      $display("[TB] FAIL evicted_miss: got %h memreqs=%0d expected 11223344bbbbbbbb 1", rd, req_cnt - r0); end
  endtask

  task automatic test_reset_stale();
    logic [63:0] rd, exp; bit hit, ok; int gc, rvc, r0, n, bad_rv, bad_cs; bit delivered;
    hold_rvalid = 1'b1;
    r0 = req_cnt;
    Req_SI = 1'b1; We_SI = 1'b0; Addr_DI = 32'h0000_1010;
    #1;
    n = 0;
    while (Gnt_SO !== 1'b1 && n < 50) begin @(negedge Clk_CI); #1; n++; end
    @(negedge Clk_CI);
    Req_SI = 1'b0;
    n = 0;
    while (req_cnt == r0 && n < 50) begin @(negedge Clk_CI); n++; end
    checks++; if (req_cnt == r0) begin errors++; $display("[TB] FAIL stale_setup: got no memreq expected one"); end
    @(negedge Clk_CI);
    Rst_RBI = 1'b0;
    #1;
    checks++; if ({RValid_SO, MemReq_SO, ArrCSel_SO} !== 3'b0) begin errors++;
      $display("[TB] FAIL midreset_outputs: got %b expected 000", {RValid_SO, MemReq_SO, ArrCSel_SO}); end
    repeat (2) @(negedge Clk_CI);
    Rst_RBI = 1'b1;
    model_reset();
    hold_rvalid = 1'b0;
    bad_rv = 0; bad_cs = 0; delivered = 1'b0;
    repeat (8) begin
      @(negedge Clk_CI); #1;
      if (MemRValid_SI === 1'b1) delivered = 1'b1;
      if (RValid_SO !== 1'b0) bad_rv++;
      if (ArrCSel_SO !== 1'b0) bad_cs++;
    end
    checks++; if (!delivered || bad_rv != 0 || bad_cs != 0) begin errors++;
      $display("[TB] FAIL stale_rvalid: got delivered=%b rvalid=%0d csel=%0d expected 1 0 0", delivered, bad_rv, bad_cs); end
    checks++; if ({HitCnt_DO, MissCnt_DO} !== 64'd0) begin errors++;
      $display("[TB] FAIL stale_counters: got %h/%h expected 0/0", HitCnt_DO, MissCnt_DO); end
    @(negedge Clk_CI);
    r0 = req_cnt;
    model_step(1'b0, 32'h0000_1008, 8'h00, 64'd0, hit, exp);
    core_access(1'b0, 32'h0000_1008, 8'h00, 64'd0, rd, gc, rvc, ok);
    checks++; if (ok !== 1'b1 || req_cnt - r0 != 1 || rd !== exp) begin errors++;
      $display("[TB] FAIL post_reset_miss: got %h memreqs=%0d expected %h 1", rd, req_cnt - r0, exp); end
  endtask

  task automatic test_hold_req();
    logic [63:0] exp; bit hit; int n, gc, early; bit seen;
    Req_SI = 1'b1; We_SI = 1'b0; Addr_DI = 32'h0000_5018;
    model_step(1'b0, 32'h0000_5018, 8'h00, 64'd0, hit, exp);
    #1;
    n = 0;
    while (Gnt_SO !== 1'b1 && n < 50) begin @(negedge Clk_CI); #1; n++; end
    early = 0; seen = 1'b0; n = 0;
    while (!seen && n < 200) begin
      @(negedge Clk_CI); #1; n++;
      if (RValid_SO === 1'b1) seen = 1'b1;
      if (Gnt_SO !== 1'b0) early++;
    end
    checks++; if (!seen || RData_DO !== exp || early != 0) begin errors++;
      $display("[TB] FAIL hold_refill: got seen=%b data=%h early_gnt=%0d expected 1 %h 0", seen, RData_DO, early, exp); end
    @(negedge Clk_CI); #1;
    checks++; if (Gnt_SO !== 1'b1) begin errors++; $display("[TB] FAIL hold_regrant: got %b expected 1", Gnt_SO); end
    model_step(1'b0, 32'h0000_5018, 8'h00, 64'd0, hit, exp);
    gc = cyc;
    @(negedge Clk_CI);
    Req_SI = 1'b0;
    #1;
    n = 0;
    while (RValid_SO !== 1'b1 && n < 50) begin @(negedge Clk_CI); #1; n++; end
    checks++; if (RValid_SO !== 1'b1 || RData_DO !== exp || cyc - gc != ARR_LATENCY) begin errors++;
      $display("[TB] FAIL hold_hit: got rv=%b data=%h lat=%0d expected 1 %h %0d", RValid_SO, RData_DO, cyc - gc, exp, ARR_LATENCY); end
    @(negedge Clk_CI);
    checks++; if (HitCnt_DO !== exp_hits() || MissCnt_DO !== exp_misses()) begin errors++;
      $display("[TB] FAIL hold_counters: got %0d/%0d expected %0d/%0d", HitCnt_DO, MissCnt_DO, exp_hits(), exp_misses()); end
  endtask

  task automatic test_random();
    logic [63:0] rd, exp, wd; logic [31:0] a; logic [7:0] ben;
    bit we, hit, ok; int gc, rvc, r0, w0, exp_req, exp_wr;
    for (int i = 0; i < 150; i++) begin
      a   = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 3) | 32'($urandom_range(0, 7));
      we  = ($urandom_range(0, 2) == 0);
      ben = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      wd  = {$urandom, $urandom};
      r0 = req_cnt; w0 = wr_cnt;
      model_step(we, a, ben, wd, hit, exp);
      core_access(we, a, ben, wd, rd, gc, rvc, ok);
      exp_req = (we || !hit) ? 1 : 0;
      exp_wr  = hit ? (we ? 1 : 0) : (we ? 0 : 1);
      checks++; if (ok !== 1'b1 || rd !== exp) begin errors++;
        $display("[TB] FAIL rnd_data[%0d]: we=%b addr=%h got %h expected %h", i, we, a, rd, exp); end
      checks++; if (req_cnt - r0 != exp_req || wr_cnt - w0 != exp_wr) begin errors++;
        $display("[TB] FAIL rnd_traffic[%0d]: we=%b addr=%h got memreqs=%0d sramwrites=%0d expected %0d %0d", i, we, a, req_cnt - r0, wr_cnt - w0, exp_req, exp_wr); end
      if (exp_req == 1) begin
        checks++; if (last_req_addr !== {a[31:3], 3'b000} || last_req_ben !== (we ? ben : 8'hFF)) begin errors++;
          $display("[TB] FAIL rnd_memreq[%0d]: got addr=%h ben=%h expected %h %h", i, last_req_addr, last_req_ben, {a[31:3], 3'b000}, we ? ben : 8'hFF); end
      end
      if (!we && hit) begin
        checks++; if (rvc - gc != ARR_LATENCY) begin errors++; $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", i, rvc - gc, ARR_LATENCY); end
      end
    end
    checks++; if (HitCnt_DO !== exp_hits() || MissCnt_DO !== exp_misses()) begin errors++;
      $display("[TB] FAIL rnd_counters: got %0d/%0d expected %0d/%0d", HitCnt_DO, MissCnt_DO, exp_hits(), exp_misses()); end
  endtask

  initial begin
    @(negedge Clk_CI);
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_write_miss_evict();
    test_reset_stale();
    test_hold_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
